// File: rtl/ws2812_pkg.sv
// ws2812_pkg: WS2812 line timing, receiver state encoding and error codes shared by TX and RX.
package ws2812_pkg;
  localparam int T0H_CYC   = 80;
  localparam int T1H_CYC   = 160;
  localparam int TBIT_CYC  = 250;
  localparam int RESET_CYC = 10000;
  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW} rx_state_e;
  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_SHORT   = 2'b01,
    ERR_LONG    = 2'b10,
    ERR_PARTIAL = 2'b11
  } err_code_e;
endpackage

// File: rtl/ws2812_rx_decoder_if.sv
// ws2812_rx_decoder_if: decoded pixel, frame and error outputs of the WS2812 receiver.
interface ws2812_rx_decoder_if #(parameter int PIX_W = 10);
  logic [23:0]      rx_data;
  logic             rx_valid;
  logic [PIX_W-1:0] pixel_idx;
  logic             frame_done;
  logic [PIX_W-1:0] frame_len;
  logic             err;
  logic [1:0]       err_code;
  modport master (output rx_data, rx_valid, pixel_idx, frame_done, frame_len, err, err_code);
  modport slave  (input  rx_data, rx_valid, pixel_idx, frame_done, frame_len, err, err_code);
endinterface

// File: rtl/ws_sync_edge.sv
// ws_sync_edge: 2-FF synchronizer for an async input plus rise/fall detect on the synced level.
module ws_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] sh_q;
  always_ff @(posedge clk) begin
    if (!rst_n) sh_q <= '0;
    else        sh_q <= {sh_q[1:0], d_i};
  end
  assign s_o    = sh_q[1];
  assign rise_o = sh_q[1] & ~sh_q[2];
  assign fall_o = ~sh_q[1] & sh_q[2];
endmodule

// File: rtl/ws2812_rx_decoder.sv
// ws2812_rx_decoder: recovers 24-bit words, pixel index and frame boundaries from a WS2812 line.
module ws2812_rx_decoder
  import ws2812_pkg::*;
#(
  parameter int THRESH_CYC   = 120,
  parameter int MIN_HIGH_CYC = 30,
  parameter int MAX_HIGH_CYC = 220,
  parameter int RESET_CYCLES = RESET_CYC,
  parameter int PIX_W        = 10
) (
  input logic                 sys_clk,
  input logic                 sys_rst_n,
  input logic                 ws_in,
  ws2812_rx_decoder_if.master rx
);
  localparam int HW = $clog2(MAX_HIGH_CYC + 2);
  localparam int LW = $clog2(RESET_CYCLES + 1);
  logic ws_s, rise, fall, word_done, drop;
  rx_state_e state_q, state_d;
  err_code_e err_code_q, err_code_d;
  logic [HW-1:0] hi_cnt_q, hi_cnt_d;
  logic [LW-1:0] lo_cnt_q, lo_cnt_d;
  logic [23:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d, pixel_idx_q, pixel_idx_d, frame_len_q, frame_len_d;
  logic any_bit_q, any_bit_d, rx_valid_q, rx_valid_d, frame_done_q, frame_done_d, err_q, err_d;

  ws_sync_edge u_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d_i   (ws_in),
    .s_o   (ws_s),
    .rise_o(rise),
    .fall_o(fall)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q      <= S_SYNC;
      err_code_q   <= ERR_NONE;
      hi_cnt_q     <= '0;
      lo_cnt_q     <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      bit_cnt_q    <= '0;
      pix_cnt_q    <= '0;
      pixel_idx_q  <= '0;
      frame_len_q  <= '0;
      any_bit_q    <= 1'b0;
      rx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_code_q   <= err_code_d;
      hi_cnt_q     <= hi_cnt_d;
      lo_cnt_q     <= lo_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      bit_cnt_q    <= bit_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      pixel_idx_q  <= pixel_idx_d;
      frame_len_q  <= frame_len_d;
      any_bit_q    <= any_bit_d;
      rx_valid_q   <= rx_valid_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  // A full word is published the cycle after its 24th fall, ahead of any frame end.
  always_comb begin
    state_d      = state_q;
    hi_cnt_d     = !ws_s ? '0 : rise ? HW'(1) :
                   (hi_cnt_q == HW'(MAX_HIGH_CYC + 1) ? hi_cnt_q : hi_cnt_q + HW'(1));
    lo_cnt_d     = ws_s ? '0 : (lo_cnt_q == LW'(RESET_CYCLES) ? lo_cnt_q : lo_cnt_q + LW'(1));
    word_done    = bit_cnt_q == 5'd24;
    drop         = 1'b0;
    shift_d      = shift_q;
    bit_cnt_d    = word_done ? 5'd0 : bit_cnt_q;
    pix_cnt_d    = pix_cnt_q + PIX_W'(word_done);
    any_bit_d    = any_bit_q;
    rx_valid_d   = word_done;
    rx_data_d    = word_done ? shift_q : rx_data_q;
    pixel_idx_d  = word_done ? pix_cnt_q : pixel_idx_q;
    frame_done_d = 1'b0;
    frame_len_d  = frame_len_q;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    case (state_q)
      S_SYNC: state_d = lo_cnt_q == LW'(RESET_CYCLES) ? S_IDLE : S_SYNC;
      S_IDLE: state_d = rise ? S_HIGH : S_IDLE;
      S_HIGH: begin
        if (hi_cnt_q > HW'(MAX_HIGH_CYC)) begin
          err_d      = 1'b1;
          err_code_d = ERR_LONG;
          drop       = 1'b1;
          state_d    = S_SYNC;
        end else if (fall && hi_cnt_q < HW'(MIN_HIGH_CYC)) begin
          err_d      = 1'b1;
          err_code_d = ERR_SHORT;
          drop       = 1'b1;
          state_d    = S_SYNC;
        end else if (fall) begin
          shift_d   = {shift_q[22:0], hi_cnt_q >= HW'(THRESH_CYC)};
          bit_cnt_d = bit_cnt_d + 5'd1;
          any_bit_d = 1'b1;
          state_d   = S_LOW;
        end
      end
      S_LOW: begin
        if (rise) state_d = S_HIGH;
        else if (lo_cnt_q == LW'(RESET_CYCLES)) begin
          err_d        = bit_cnt_d != 5'd0;
          err_code_d   = bit_cnt_d != 5'd0 ? ERR_PARTIAL : err_code_q;
          frame_done_d = any_bit_q;
          frame_len_d  = any_bit_q ? pix_cnt_d : frame_len_q;
          pix_cnt_d    = '0;
          bit_cnt_d    = '0;
          any_bit_d    = 1'b0;
          state_d      = S_IDLE;
        end
      end
    endcase
    if (drop) begin
      bit_cnt_d = '0;
      pix_cnt_d = '0;
      any_bit_d = 1'b0;
    end
  end

  assign rx.rx_data    = rx_data_q;
  assign rx.rx_valid   = rx_valid_q;
  assign rx.pixel_idx  = pixel_idx_q;
  assign rx.frame_done = frame_done_q;
  assign rx.frame_len  = frame_len_q;
  assign rx.err        = err_q;
  assign rx.err_code   = err_code_q;
endmodule

// File: doc/ws2812_rx_decoder.md
Name: ws2812_rx_decoder

Overview:
- Single-wire WS2812 stream receiver: the receive end of the LED serial protocol driven by the RGB_control_Top `ws` output.
- Recovers 24-bit pixel words, pixel index and frame boundaries from the pulse-width-coded line.
- Used in loopback self-check (ws -> ws_in) and for re-capturing downstream strip data.
- Runs entirely in the 200 MHz system domain.

Parameters:
- THRESH_CYC, 120: high-pulse width (cycles) at/above which bit = 1; below = 0 (T0H 80, T1H 160 at 200 MHz).
- MIN_HIGH_CYC, 30: high pulse shorter than this = glitch error.
- MAX_HIGH_CYC, 220: high pulse longer than this = stuck-high error.
- RESET_CYCLES, 10000: continuous low width (50 us) that ends a frame.
- PIX_W, 10: width of pixel index / frame length counters.

Ports:
- sys_clk  in  1  200 MHz clock, sole clock.
- sys_rst_n  in  1  reset, synchronous, active-low.
- ws_in  in  1  raw asynchronous WS2812 line.
- rx_data  out  24  decoded word; bit 23 = first bit received.
- rx_valid  out  1  one-cycle strobe, rx_data/pixel_idx valid.
- pixel_idx  out  PIX_W  index of rx_data within the current frame, 0-based.
- frame_done  out  1  one-cycle strobe on reset gap after at least one bit.
- frame_len  out  PIX_W  complete words in the finished frame, valid with frame_done.
- err  out  1  one-cycle error strobe.
- err_code  out  2  01 short pulse, 10 long pulse, 11 partial word; held until next err.

Behaviour:
- Reset (sys_rst_n=0 at a sys_clk edge): all outputs 0; state S_SYNC; counters, shift register and bit count cleared.
- Input sync: ws_in passes through a 2-FF synchronizer to give ws_s; ws_d = ws_s delayed 1 cycle.
- Edges: rise = ws_s & ~ws_d; fall = ~ws_s & ws_d.
- hi_cnt: counts while ws_s=1 and saturates at MAX_HIGH_CYC+1.
- lo_cnt: counts while ws_s=0 and saturates at RESET_CYCLES.
- S_SYNC: stays here until lo_cnt reaches RESET_CYCLES, then goes to S_IDLE. No frame_done is emitted here. A rise before that point restarts the low count.
- S_IDLE: on rise, goes to S_HIGH and sets hi_cnt=1.
- S_HIGH, on the fall cycle:
  - hi_cnt < MIN_HIGH_CYC: err, code 01; discard the partial word and frame; go to S_SYNC.
  - otherwise shift in (hi_cnt >= THRESH_CYC); bit_cnt++; go to S_LOW.
- S_HIGH, overflow: if hi_cnt exceeds MAX_HIGH_CYC while still high, err with code 10, then go to S_SYNC immediately.
- S_LOW, rise: go to S_HIGH.
- S_LOW, lo_cnt reaches RESET_CYCLES (end of frame):
  - bit_cnt≠0: err with code 11 on the same cycle.
  - frame_done=1 and frame_len = pixel count if ≥1 bit was received in the frame.
  - clear pixel count and bit_cnt; go to S_IDLE.
- Word completion: on the fall that makes bit_cnt=24, the next cycle drives rx_data = word, rx_valid=1, pixel_idx = count; then count++ and bit_cnt=0.
- Latency: rx_valid fires 4 sys_clk cycles after the raw falling edge of the 24th bit (2 sync + 1 edge detect + 1 output register).
- Pixel counter: wraps modulo 2^PIX_W and flags no error. frame_len reports the wrapped value.
- Priority on a shared cycle: word completion before frame end, so frame_done is never earlier than the last rx_valid. err and frame_done may both be 1 on the same cycle.
- Mid-operation reset: acts immediately, with no partial outputs afterwards; re-sync requires a full RESET_CYCLES low.
- Held outputs: rx_data holds its last value between strobes. err_code holds until the next err.

Decomposition:
- Shared package ws2812_pkg holds:
  - timing constants (T0H/T1H/TBIT/RESET in 200 MHz cycles), shared with the transmitter;
  - the state encoding (S_SYNC, S_IDLE, S_HIGH, S_LOW);
  - the err_code encodings.
- One natural sub-module, ws_sync_edge: 2-FF synchronizer plus rise/fall detect, reusable for the other async inputs.

Test Plan:
- Reset, 10000-cycle low, then 24 bits of 0xA5C3F0 (T1H=160/T0H=80, bit period 250), then a 50 us low:
  - rx_valid once with rx_data=0xA5C3F0, pixel_idx=0;
  - frame_done with frame_len=1.
- Three words 0x000000, 0xFFFFFF, 0x123456, then a gap -> pixel_idx 0, 1, 2 with matching data; frame_len=3.
- Line starts high / no initial gap; bits sent before the first 10000-cycle low -> no rx_valid and no err until after the gap.
- 20-cycle high pulse mid-word -> err=1, err_code=01; that word is dropped; the next frame after a gap decodes normally.
- 10 bits then a 50 us low -> err_code=11 and frame_done with frame_len=0; no rx_valid.
- Line held high for 300 cycles -> err_code=10 at hi_cnt=221; reset asserted mid-word -> all outputs 0 on the next cycle.
